sdram_port_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single SDRAM master port between the word-copy engine and the DNN accelerator datapath. It grants one transfer per grant with round-robin fairness and tracks outstanding pipelined reads. It routes each `readdatavalid` beat back to the requester that issued the read. The block sits between the two accelerator masters and the SDRAM controller slave inside the accelerator system.

---
 rtl/sdram_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one Avalon-MM SDRAM master port between two requesters
//               (0 = word-copy engine, 1 = DNN accelerator datapath). One
//               transfer is granted per grant, with round-robin fairness.
//               Pipelined reads are tagged in a small FIFO so that each
//               readdatavalid beat is routed back to the requester that
//               issued the read.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               r{0,1}_read_i/_write_i   - requester commands
//               r{0,1}_address_i         - requester address
//               r{0,1}_writedata_i       - requester write data
//               r{0,1}_waitrequest_o     - stall back to requester
//               r{0,1}_readdata_o        - read data (broadcast)
//               r{0,1}_readdatavalid_o   - read beat belongs to this requester
//               master_*                 - Avalon-MM master side to SDRAM
//               outstanding_o            - reads accepted but not yet returned
//               err_rdv_o                - sticky: beat arrived with no read
//                                          outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // requester 0 (word-copy)
    input  logic                         r0_read_i,
    input  logic                         r0_write_i,
    input  logic [31:0]                  r0_address_i,
    input  logic [31:0]                  r0_writedata_i,
    output logic                         r0_waitrequest_o,
    output logic [31:0]                  r0_readdata_o,
    output logic                         r0_readdatavalid_o,
    // requester 1 (accelerator)
    input  logic                         r1_read_i,
    input  logic                         r1_write_i,
    input  logic [31:0]                  r1_address_i,
    input  logic [31:0]                  r1_writedata_i,
    output logic                         r1_waitrequest_o,
    output logic [31:0]                  r1_readdata_o,
    output logic                         r1_readdatavalid_o,
    // SDRAM master port
    input  logic                         master_waitrequest_i,
    output logic [31:0]                  master_address_o,
    output logic [31:0]                  master_writedata_o,
    output logic                         master_read_o,
    output logic                         master_write_o,
    input  logic [31:0]                  master_readdata_i,
    input  logic                         master_readdatavalid_i,
    // status
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
    output logic                         err_rdv_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = $clog2(MAX_OUT);

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic               gnt_id_q,  gnt_id_d;
    logic               last_id_q, last_id_d;
    logic [MAX_OUT-1:0] tag_q,     tag_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               err_q,     err_d;

    logic        w_req0;
    logic        w_req1;
    logic        w_winner;
    logic        w_g_read;
    logic        w_g_write;
    logic [31:0] w_g_addr;
    logic [31:0] w_g_wdata;
    logic        w_g_req;
    logic        w_g_is_read;
    logic        w_granted;
    logic        w_cnt_empty;
    logic        w_pop;
    logic        w_full_block;
    logic        w_g_wait;
    logic        w_accept;
    logic        w_push;
    logic        w_head_tag;

    // ------------------------------------------------------------------
    // Request decode and granted-requester mux
    // ------------------------------------------------------------------
    assign w_req0   = r0_read_i | r0_write_i;
    assign w_req1   = r1_read_i | r1_write_i;
    // On a tie the requester that did not win last time goes next.
    assign w_winner = (w_req0 & w_req1) ? ~last_id_q : w_req1;

    assign w_g_read    = gnt_id_q ? r1_read_i      : r0_read_i;
    assign w_g_write   = gnt_id_q ? r1_write_i     : r0_write_i;
    assign w_g_addr    = gnt_id_q ? r1_address_i   : r0_address_i;
    assign w_g_wdata   = gnt_id_q ? r1_writedata_i : r0_writedata_i;
    assign w_g_req     = w_g_read | w_g_write;
    // Write takes precedence when both command bits are set.
    assign w_g_is_read = w_g_read & ~w_g_write;
    assign w_granted   = (state_q == ST_GRANT);

    // ------------------------------------------------------------------
    // Tag FIFO status
    // ------------------------------------------------------------------
    assign w_cnt_empty = (cnt_q == '0);
    assign w_pop       = master_readdatavalid_i & ~w_cnt_empty;
    // A beat returning this cycle frees a slot that a read accepted in the
    // same cycle may reuse. When full, wr_ptr == rd_ptr, so the new tag
    // overwrites exactly the head entry that is being consumed right now.
    assign w_full_block = (cnt_q == C_CNT_FULL) & ~w_pop;

    assign w_g_wait   = master_waitrequest_i | (w_g_is_read & w_full_block);
    assign w_accept   = w_granted & w_g_req & ~w_g_wait;
    assign w_push     = w_accept & w_g_is_read;
    assign w_head_tag = tag_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Datapath outputs
    // ------------------------------------------------------------------
    always_comb begin
        r0_waitrequest_o   = 1'b1;
        r1_waitrequest_o   = 1'b1;
        master_address_o   = 32'h0;
        master_writedata_o = 32'h0;
        master_read_o      = 1'b0;
        master_write_o     = 1'b0;
        if (w_granted) begin
            master_address_o   = w_g_addr;
            master_writedata_o = w_g_wdata;
            master_write_o     = w_g_write;
            master_read_o      = w_g_is_read & ~w_full_block;
            if (gnt_id_q) begin
                r1_waitrequest_o = w_g_wait;
            end else begin
                r0_waitrequest_o = w_g_wait;
            end
        end
    end

    // Read return adds no latency: the head tag steers the beat directly.
    assign r0_readdata_o      = master_readdata_i;
    assign r1_readdata_o      = master_readdata_i;
    assign r0_readdatavalid_o = w_pop & ~w_head_tag;
    assign r1_readdatavalid_o = w_pop &  w_head_tag;

    assign outstanding_o = cnt_q;
    assign err_rdv_o     = err_q;

    // ------------------------------------------------------------------
    // Next-state logic: arbitration FSM, tag FIFO, counter, error flag
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    gnt_id_d  = w_winner;
                    last_id_d = w_winner;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // One transfer per grant; a withdrawn request also releases.
                if (w_accept | ~w_g_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_push) begin
            tag_d[wr_ptr_q] = gnt_id_q;
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        if (w_push & ~w_pop) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end else if (w_pop & ~w_push) begin
            cnt_d = cnt_q - C_CNT_ONE;
        end

        if (master_readdatavalid_i & w_cnt_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_id_q  <= 1'b0;
            last_id_q <= 1'b1;
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Self-checking bench for sdram_port_arbiter. Directed scenarios
//               followed by randomized traffic, all compared every cycle
//               against a transaction-level model (grant owner, tag queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int MAX_OUT = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_read, r0_write, r1_read, r1_write;
    logic [31:0]       r0_address, r0_writedata, r1_address, r1_writedata;
    logic              r0_waitrequest, r1_waitrequest;
    logic [31:0]       r0_readdata, r1_readdata;
    logic              r0_readdatavalid, r1_readdatavalid;
    logic              master_waitrequest;
    logic [31:0]       master_address, master_writedata;
    logic              master_read, master_write;
    logic [31:0]       master_readdata;
    logic              master_readdatavalid;
    logic [CNT_W-1:0]  outstanding;
    logic              err_rdv;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .r0_read_i              (r0_read),
        .r0_write_i             (r0_write),
        .r0_address_i           (r0_address),
        .r0_writedata_i         (r0_writedata),
        .r0_waitrequest_o       (r0_waitrequest),
        .r0_readdata_o          (r0_readdata),
        .r0_readdatavalid_o     (r0_readdatavalid),
        .r1_read_i              (r1_read),
        .r1_write_i             (r1_write),
        .r1_address_i           (r1_address),
        .r1_writedata_i         (r1_writedata),
        .r1_waitrequest_o       (r1_waitrequest),
        .r1_readdata_o          (r1_readdata),
        .r1_readdatavalid_o     (r1_readdatavalid),
        .master_waitrequest_i   (master_waitrequest),
        .master_address_o       (master_address),
        .master_writedata_o     (master_writedata),
        .master_read_o          (master_read),
        .master_write_o         (master_write),
        .master_readdata_i      (master_readdata),
        .master_readdatavalid_i (master_readdatavalid),
        .outstanding_o          (outstanding),
        .err_rdv_o              (err_rdv)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who currently holds the grant, who won last, and the
    // ordered list of requesters whose reads are still in flight.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = 1;
    int m_tags[$];
    bit m_err   = 1'b0;

    // Per-cycle expectations derived from the model.
    logic        e_w0, e_w1, e_mr, e_mw, e_v0, e_v1;
    logic [31:0] e_addr, e_wdata;
    bit          e_accept, e_pop, e_is_read, e_greq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_eval();
        logic        rd, wr, stall;
        logic [31:0] a, d;
        bit          blocked;
        e_w0 = 1'b1; e_w1 = 1'b1; e_mr = 1'b0; e_mw = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0;
        e_accept = 1'b0; e_is_read = 1'b0; e_greq = 1'b0;
        e_v0 = 1'b0; e_v1 = 1'b0;
        e_pop = master_readdatavalid && (m_tags.size() > 0);
        if (e_pop) begin
            e_v0 = (m_tags[0] == 0);
            e_v1 = (m_tags[0] == 1);
        end
        if (m_busy) begin
            rd = (m_owner == 0) ? r0_read      : r1_read;
            wr = (m_owner == 0) ? r0_write     : r1_write;
            a  = (m_owner == 0) ? r0_address   : r1_address;
            d  = (m_owner == 0) ? r0_writedata : r1_writedata;
            e_greq    = rd || wr;
            e_is_read = rd && !wr;
            blocked   = e_is_read && (m_tags.size() == MAX_OUT) && !e_pop;
            stall     = master_waitrequest || blocked;
            e_mw = wr; e_mr = e_is_read && !blocked;
            e_addr = a; e_wdata = d;
            if (m_owner == 0) e_w0 = stall; else e_w1 = stall;
            e_accept = e_greq && !stall;
        end
    endfunction

    function automatic void model_update();
        bit q0, q1;
        if (rst) begin
            m_busy = 1'b0; m_last = 1; m_tags.delete(); m_err = 1'b0;
        end else begin
            if (e_pop) void'(m_tags.pop_front());
            else if (master_readdatavalid) m_err = 1'b1;
            if (e_accept && e_is_read) m_tags.push_back(m_owner);
            if (m_busy) begin
                if (e_accept || !e_greq) m_busy = 1'b0;
            end else begin
                q0 = r0_read || r0_write;
                q1 = r1_read || r1_write;
                if (q0 || q1) begin
                    m_owner = (q0 && q1) ? (1 - m_last) : (q0 ? 0 : 1);
                    m_last  = m_owner;
                    m_busy  = 1'b1;
                end
            end
        end
    endfunction

    // Let combinational outputs settle, then compare everything to the model.
    task automatic settle();
        #2;
        if (!rst) begin
            model_eval();
            chk("r0_waitrequest",   r0_waitrequest,   e_w0);
            chk("r1_waitrequest",   r1_waitrequest,   e_w1);
            chk("master_read",      master_read,      e_mr);
            chk("master_write",     master_write,     e_mw);
            chk("master_address",   master_address,   e_addr);
            chk("master_writedata", master_writedata, e_wdata);
            chk("r0_readdatavalid", r0_readdatavalid, e_v0);
            chk("r1_readdatavalid", r1_readdatavalid, e_v1);
            chk("r0_readdata",      r0_readdata,      master_readdata);
            chk("r1_readdata",      r1_readdata,      master_readdata);
            chk("outstanding",      32'(outstanding), m_tags.size());
            chk("err_rdv",          err_rdv,          m_err);
        end
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        settle();
        adv();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          grants[$];
        int          wcyc[$];
        int          due[$];
        logic [31:0] dat[$];
        logic [31:0] got0[$];
        logic [31:0] got1[$];
        logic [31:0] tbl[3];
        int          peak, nissued, r0_n, r1_n, acc, nw;

        rst = 1'b1;
        r0_read = 0; r0_write = 0; r0_address = 0; r0_writedata = 0;
        r1_read = 0; r1_write = 0; r1_address = 0; r1_writedata = 0;
        master_waitrequest = 0; master_readdata = 0; master_readdatavalid = 0;

        // ---------------- reset state ----------------
        settle(); adv();
        settle(); adv();
        rst = 1'b0;
        settle();
        chk("reset r0_waitrequest", r0_waitrequest, 1);
        chk("reset r1_waitrequest", r1_waitrequest, 1);
        chk("reset master_read",    master_read,    0);
        chk("reset master_write",   master_write,   0);
        chk("reset outstanding",    32'(outstanding), 0);
        chk("reset err_rdv",        err_rdv,        0);
        adv();

        // ---------------- single write, requester 0 ----------------
        r0_write = 1; r0_address = 32'h100; r0_writedata = 32'hDEADBEEF;
        nw = 0;
        settle();
        chk("sw idle r0_waitrequest", r0_waitrequest, 1);
        nw += int'(master_write === 1'b1);
        adv();
        settle();
        chk("sw master_address",   master_address,   32'h100);
        chk("sw master_writedata", master_writedata, 32'hDEADBEEF);
        chk("sw r0_waitrequest",   r0_waitrequest,   0);
        nw += int'(master_write === 1'b1);
        adv();
        r0_write = 0;
        settle();
        chk("sw back idle r0_waitrequest", r0_waitrequest, 1);
        nw += int'(master_write === 1'b1);
        adv();
        chk("sw write cycles", nw, 1);

        // ---------------- contention ----------------
        reset_pulse();
        r0_write = 1; r0_address = 32'h200; r0_writedata = 32'h11;
        r1_write = 1; r1_address = 32'h300; r1_writedata = 32'h22;
        for (int i = 0; i < 16; i++) begin
            settle();
            if (master_write === 1'b1) begin
                grants.push_back((master_address == 32'h300) ? 1 : 0);
                wcyc.push_back(i);
            end
            adv();
        end
        r0_write = 0; r1_write = 0;
        settle(); adv();
        chk("cont transfers", grants.size(), 8);
        for (int k = 0; k < grants.size(); k++) begin
            chk("cont grant order", grants[k], k % 2);
            if (k > 0) chk("cont spacing", wcyc[k] - wcyc[k-1], 2);
        end

        // ---------------- interleaved reads and return routing ----------------
        reset_pulse();
        tbl[0] = 32'hA; tbl[1] = 32'hB; tbl[2] = 32'hC;
        peak = 0; nissued = 0; r0_n = 0; r1_n = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            r0_read    = (r0_n < 2);
            r0_address = (r0_n == 0) ? 32'h10 : 32'h30;
            r1_read    = (r1_n < 1);
            r1_address = 32'h20;
            if (due.size() > 0 && due[0] == cyc) begin
                master_readdatavalid = 1'b1;
                master_readdata      = dat[0];
                void'(due.pop_front());
                void'(dat.pop_front());
            end else begin
                master_readdatavalid = 1'b0;
                master_readdata      = 32'h0;
            end
            settle();
            if (r0_readdatavalid === 1'b1) got0.push_back(r0_readdata);
            if (r1_readdatavalid === 1'b1) got1.push_back(r1_readdata);
            if (int'(outstanding) > peak) peak = int'(outstanding);
            if (master_read === 1'b1 && !master_waitrequest && nissued < 3) begin
                due.push_back(cyc + 3);
                dat.push_back(tbl[nissued]);
                nissued++;
            end
            if (r0_read && r0_waitrequest === 1'b0) r0_n++;
            if (r1_read && r1_waitrequest === 1'b0) r1_n++;
            adv();
        end
        chk("rd r0 beats", got0.size(), 2);
        chk("rd r1 beats", got1.size(), 1);
        if (got0.size() == 2) begin
            chk("rd r0 first",  got0[0], 32'hA);
            chk("rd r0 second", got0[1], 32'hC);
        end
        if (got1.size() == 1) chk("rd r1 first", got1[0], 32'hB);
        chk("rd outstanding peak", peak, 2);
        chk("rd outstanding final", 32'(outstanding), 0);

        // ---------------- FIFO full backpressure ----------------
        reset_pulse();
        r0_read = 1; r0_address = 32'h1000; acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            settle();
            if (r0_waitrequest === 1'b0) acc++;
            adv();
        end
        chk("full accepted reads", acc, 4);
        for (int cyc = 0; cyc < 2; cyc++) begin
            settle();
            chk("full r0_waitrequest", r0_waitrequest, 1);
            chk("full master_read",    master_read,    0);
            chk("full outstanding",    32'(outstanding), 4);
            adv();
        end
        master_readdatavalid = 1; master_readdata = 32'h55;
        settle();
        chk("full pop r0_readdatavalid", r0_readdatavalid, 1);
        chk("full pop r0_waitrequest",   r0_waitrequest,   0);
        chk("full pop master_read",      master_read,      1);
        adv();
        master_readdatavalid = 0; r0_read = 0;
        settle();
        chk("full after pop outstanding", 32'(outstanding), 4);
        adv();
        master_readdatavalid = 1;
        for (int i = 0; i < 4; i++) begin
            settle(); adv();
        end
        master_readdatavalid = 0;
        settle();
        chk("full drained outstanding", 32'(outstanding), 0);
        chk("full drained err_rdv",     err_rdv,          0);
        adv();

        // ---------------- stray beat ----------------
        master_readdatavalid = 1; master_readdata = 32'h77;
        settle();
        chk("stray r0_readdatavalid", r0_readdatavalid, 0);
        chk("stray r1_readdatavalid", r1_readdatavalid, 0);
        adv();
        master_readdatavalid = 0;
        settle();
        chk("stray err_rdv set", err_rdv, 1);
        adv();
        for (int i = 0; i < 3; i++) begin
            settle(); adv();
        end
        settle();
        chk("stray err_rdv sticky", err_rdv, 1);
        adv();

        // ---------------- SDRAM stall during grant ----------------
        r1_write = 1; r1_address = 32'h444; r1_writedata = 32'h1234;
        master_waitrequest = 1;
        settle(); adv();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall r1_waitrequest",  r1_waitrequest, 1);
            chk("stall master_address",  master_address, 32'h444);
            chk("stall master_write",    master_write,   1);
            adv();
        end
        master_waitrequest = 0;
        settle();
        chk("stall release r1_waitrequest", r1_waitrequest, 0);
        adv();
        r1_write = 0;
        settle(); adv();
        reset_pulse();
        settle();
        chk("err_rdv cleared by rst", err_rdv, 0);
        adv();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            rst                  = ($urandom_range(0, 149) == 0);
            r0_read              = ($urandom_range(0, 2) != 0);
            r0_write             = ($urandom_range(0, 3) == 0);
            r1_read              = ($urandom_range(0, 2) != 0);
            r1_write             = ($urandom_range(0, 3) == 0);
            r0_address           = $urandom;
            r0_writedata         = $urandom;
            r1_address           = $urandom;
            r1_writedata         = $urandom;
            master_waitrequest   = ($urandom_range(0, 3) == 0);
            master_readdata      = $urandom;
            master_readdatavalid = (i < 200) ? ($urandom_range(0, 7) == 0)
                                             : ($urandom_range(0, 1) == 0);
            settle();
            adv();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
